rf_multiport_sb: RTL and testbench

- Parametrised successor to the core's integer register file.
- Configurable depth, data width and number of read ports.
- One write port with byte-granular enables; register 0 is hardwired to zero.
- Adds a per-register busy scoreboard, so the issue stage can track registers with outstanding multi-cycle producers (loads, divides) and stall on them.
- Sits between decode/issue (reads, busy set) and writeback (write, busy clear).

---
 rtl/rf_pkg.sv | 26 ++
 rtl/rf_scoreboard.sv | 35 +++
 rtl/rf_multiport_sb.sv | 84 ++++++++
 tb/tb_rf_multiport_sb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multiport register file.
// Byte merge is sized for the widest supported word; callers cast down.
package rf_pkg;

  localparam int DEPTH_D  = 32;
  localparam int WIDTH_D  = 32;
  localparam int NUM_RD_D = 2;
  localparam int REG0     = 0;

  localparam int MAX_W = 256;
  localparam int MAX_B = MAX_W / 8;

  function automatic logic [MAX_W-1:0] byte_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_B-1:0] be
  );
    logic [MAX_W-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_B; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits; a same-edge set beats a clear.
// Bit 0 never becomes busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH = DEPTH_D,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_busy,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_busy,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] busy,
  output logic             any_busy
);

  logic [DEPTH-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (clr_busy) busy_nxt[clr_addr] = 1'b0;
    if (set_busy) busy_nxt[set_addr] = 1'b1;
    busy_nxt[REG0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  assign any_busy = |busy;

endmodule

// File: rtl/rf_multiport_sb.sv
// Multiport integer register file with busy scoreboard.
// Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module rf_multiport_sb
  import rf_pkg::*;
#(
  parameter int DEPTH  = DEPTH_D,
  parameter int WIDTH  = WIDTH_D,
  parameter int NUM_RD = NUM_RD_D,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [BW-1:0]        wbe,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD*WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]    rbusy,
  input  logic                 set_busy,
  input  logic [AW-1:0]        set_addr,
  input  logic                 clr_busy,
  output logic                 any_busy
);

  localparam logic [AW-1:0] REG0_A = AW'(REG0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [WIDTH-1:0] wmerged;
  logic             wr_hit;

  assign wr_hit  = we && (waddr != REG0_A);
  assign wmerged = WIDTH'(byte_merge(MAX_W'(mem[waddr]),
                                     MAX_W'(wdata),
                                     MAX_B'(wbe)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_hit) begin
      mem[waddr] <= wmerged;
    end
  end

  rf_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .clr_busy (clr_busy),
    .clr_addr (waddr),
    .busy     (busy),
    .any_busy (any_busy)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] word;
    logic             b;

    assign ra = raddr[p*AW +: AW];

    always_comb begin
      word = mem[ra];
      b    = busy[ra];
`ifdef RF_BYPASS_EN
      if (wr_hit && (ra == waddr)) begin
        word = wmerged;
        if (clr_busy) b = 1'b0;
      end
`endif
      if (ra == REG0_A) begin
        word = '0;
        b    = 1'b0;
      end
    end

    assign rdata[p*WIDTH +: WIDTH] = word;
    assign rbusy[p] = b;
  end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed and randomized checks for rf_multiport_sb.
// Default parameters: DEPTH=32, WIDTH=32, NUM_RD=2.
module tb_rf_multiport_sb;

  localparam int AW = 5;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [3:0]    wbe;
  logic [2*AW-1:0] raddr;
  logic [2*W-1:0]  rdata;
  logic [1:0]    rbusy;
  logic          set_busy;
  logic [AW-1:0] set_addr;
  logic          clr_busy;
  logic          any_busy;

  int pass_cnt = 0;
  int total    = 0;

  logic [W-1:0] mm [32];
  logic         mb [32];

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rf_multiport_sb dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wbe      (wbe),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .set_busy (set_busy),
    .set_addr (set_addr),
    .clr_busy (clr_busy),
    .any_busy (any_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    we = 1'b0; wbe = 4'h0; wdata = '0; waddr = '0;
    set_busy = 1'b0; set_addr = '0; clr_busy = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  function automatic logic [W-1:0] rd0();
    return rdata[W-1:0];
  endfunction

  function automatic logic [W-1:0] rd1();
    return rdata[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] mix(input logic [W-1:0] o,
                                       input logic [W-1:0] n,
                                       input logic [3:0] be);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] mask;
      mask = 32'hFF << (8 * i);
      r = r | ((be[i] ? n : o) & mask);
    end
    return r;
  endfunction

  initial begin
    logic [AW-1:0] ra [2];
    logic [W-1:0]  exp_d;
    logic          exp_b;
    logic          exp_any;

    idle();
    raddr = '0;
    rst = 1'b0;
    #2;
    check("rst_rdata", rdata[W-1:0] | rdata[2*W-1:W], 32'h0);
    check("rst_any", {31'b0, any_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // full-word write
    @(negedge clk);
    we = 1'b1; waddr = 5'd2; wdata = 32'd50; wbe = 4'hF;
    raddr = {5'd3, 5'd2};
    cyc();
    check("full_wr_p0", rd0(), 32'd50);
    check("full_wr_p1", rd1(), 32'd0);

    // partial writes
    we = 1'b1; waddr = 5'd5; wdata = 32'hAABBCCDD; wbe = 4'hF;
    raddr = {5'd5, 5'd5};
    cyc();
    we = 1'b1; waddr = 5'd5; wdata = 32'h11223344; wbe = 4'b0011;
    cyc();
    check("part_0011", rd0(), 32'hAABB3344);
    we = 1'b1; waddr = 5'd5; wdata = 32'h11223344; wbe = 4'b0100;
    cyc();
    check("part_0100", rd0(), 32'hAA223344);
    check("same_addr_p1", rd1(), 32'hAA223344);
    we = 1'b1; waddr = 5'd5; wdata = 32'h0; wbe = 4'b0000;
    cyc();
    check("wbe0_noop", rd0(), 32'hAA223344);

    // register 0
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF;
    set_busy = 1'b1; set_addr = 5'd0;
    raddr = {5'd0, 5'd0};
    cyc();
    check("r0_data", rd0(), 32'h0);
    check("r0_busy", {30'b0, rbusy}, 32'h0);
    check("r0_any", {31'b0, any_busy}, 32'h0);

    // scoreboard
    set_busy = 1'b1; set_addr = 5'd7;
    raddr = {5'd0, 5'd7};
    cyc();
    check("sb_set", {31'b0, rbusy[0]}, 32'h1);
    check("sb_any", {31'b0, any_busy}, 32'h1);
    we = 1'b1; waddr = 5'd7; wdata = 32'h77; wbe = 4'hF;
    clr_busy = 1'b1; set_busy = 1'b1; set_addr = 5'd7;
    cyc();
    check("sb_set_wins", {31'b0, rbusy[0]}, 32'h1);
    check("sb_wr", rd0(), 32'h77);
    waddr = 5'd7; clr_busy = 1'b1;
    cyc();
    check("sb_clr", {31'b0, rbusy[0]}, 32'h0);
    check("sb_clr_any", {31'b0, any_busy}, 32'h0);

    // bypass
    we = 1'b1; waddr = 5'd9; wdata = 32'h12345678; wbe = 4'hF;
    raddr = {5'd0, 5'd9};
    #1;
    check("byp_same", rd0(), BYP ? 32'h12345678 : 32'h0);
    cyc();
    check("byp_next", rd0(), 32'h12345678);

    // busy-bypass on clear
    set_busy = 1'b1; set_addr = 5'd9;
    cyc();
    we = 1'b1; waddr = 5'd9; wdata = 32'h1; wbe = 4'h1; clr_busy = 1'b1;
    #1;
    check("byp_busy", {31'b0, rbusy[0]}, BYP ? 32'h0 : 32'h1);
    cyc();
    check("byp_busy_next", {31'b0, rbusy[0]}, 32'h0);

    // asynchronous reset mid-operation
    set_busy = 1'b1; set_addr = 5'd3;
    cyc();
    check("pre_rst_any", {31'b0, any_busy}, 32'h1);
    we = 1'b1; waddr = 5'd2; wdata = 32'hDEADBEEF; wbe = 4'hF;
    set_busy = 1'b1; set_addr = 5'd4;
    raddr = {5'd3, 5'd9};
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_p0", rd0(), 32'h0);
    check("mid_rst_p1", rd1(), 32'h0);
    check("mid_rst_busy", {30'b0, rbusy}, 32'h0);
    check("mid_rst_any", {31'b0, any_busy}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle();
    raddr = {5'd4, 5'd2};
    #1;
    check("post_rst_wr", rd0(), 32'h0);
    check("post_rst_busy", {30'b0, rbusy}, 32'h0);

    // randomized against reference model
    for (int i = 0; i < 32; i++) begin
      mm[i] = '0;
      mb[i] = 1'b0;
    end
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      we       = 1'($urandom_range(0, 1));
      waddr    = 5'($urandom_range(0, 7));
      wdata    = $urandom;
      wbe      = 4'($urandom);
      set_busy = 1'($urandom_range(0, 1));
      set_addr = 5'($urandom_range(0, 7));
      clr_busy = 1'($urandom_range(0, 1));
      ra[0]    = 5'($urandom_range(0, 7));
      ra[1]    = 5'($urandom_range(0, 7));
      raddr    = {ra[1], ra[0]};
      #1;
      exp_any = 1'b0;
      for (int r = 0; r < 32; r++) exp_any = exp_any | mb[r];
      check("rnd_any", {31'b0, any_busy}, {31'b0, exp_any});
      for (int p = 0; p < 2; p++) begin
        exp_d = mm[ra[p]];
        exp_b = mb[ra[p]];
        if (BYP && we && waddr != 0 && ra[p] == waddr) begin
          exp_d = mix(mm[ra[p]], wdata, wbe);
          if (clr_busy) exp_b = 1'b0;
        end
        if (ra[p] == 0) begin
          exp_d = '0;
          exp_b = 1'b0;
        end
        check(p == 0 ? "rnd_d0" : "rnd_d1",
              rdata[p*W +: W], exp_d);
        check(p == 0 ? "rnd_b0" : "rnd_b1",
              {31'b0, rbusy[p]}, {31'b0, exp_b});
      end
      @(posedge clk);
      if (clr_busy) mb[waddr] = 1'b0;
      if (set_busy && set_addr != 0) mb[set_addr] = 1'b1;
      if (we && waddr != 0) mm[waddr] = mix(mm[waddr], wdata, wbe);
    end

    @(negedge clk);
    idle();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
